// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared definitions for the matrix-multiply sequencer: controller state
// encoding, accumulator data width and default geometry.
package matmul_pkg;

    localparam int DATA_W = 18;   // accumulator / C element width
    localparam int N_DEF  = 3;    // default matrix dimension
    localparam int AW_DEF = 4;    // default A/B/C address width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Handshake and datapath-control bundle for matmul_seq_ctrl.
// The master modport is the controller's view; the slave modport is the
// view of the host plus datapath. The stall signal exists only when
// MATMUL_STALL_EN is defined.
interface matmul_seq_ctrl_if #(parameter int AW = 4);

    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic [AW-1:0] addrC;
    logic          clearRes;
    logic          Reswrite;
    logic          cWrite;
`ifdef MATMUL_STALL_EN
    logic          stall;

    modport master (input start, input stall,
                    output busy, output done, output addrA, output addrB, output addrC,
                    output clearRes, output Reswrite, output cWrite);
    modport slave  (output start, output stall,
                    input busy, input done, input addrA, input addrB, input addrC,
                    input clearRes, input Reswrite, input cWrite);
`else
    modport master (input start,
                    output busy, output done, output addrA, output addrB, output addrC,
                    output clearRes, output Reswrite, output cWrite);
    modport slave  (output start,
                    input busy, input done, input addrA, input addrB, input addrC,
                    input clearRes, input Reswrite, input cWrite);
`endif

endinterface

// File: rtl/matmul_seq_ctrl_idx_cnt.sv
// Nested i/j/k index counter for the matrix-multiply sequencer.
// k advances on inc_k; inc_ij returns k to 0 and steps (i,j) row-major,
// holding at the final element. clr returns all indices to 0.
module matmul_idx_cnt #(
    parameter int N  = 3,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_k_i,
    input  logic          inc_ij_i,
    output logic [CW-1:0] i_o,
    output logic [CW-1:0] j_o,
    output logic [CW-1:0] k_o,
    output logic          last_k_o,
    output logic          last_elem_o
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] i_q, j_q, k_q;
    logic [CW-1:0] i_d, j_d, k_d;

    assign i_o         = i_q;
    assign j_o         = j_q;
    assign k_o         = k_q;
    assign last_k_o    = (k_q == LAST);
    assign last_elem_o = (i_q == LAST) && (j_q == LAST);

    // Next-index selection: clear wins, then element step, then k step.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr_i) begin
            i_d = {CW{1'b0}};
            j_d = {CW{1'b0}};
            k_d = {CW{1'b0}};
        end else if (inc_ij_i) begin
            k_d = {CW{1'b0}};
            if (last_elem_o) begin
                i_d = i_q;
            end else if (j_q == LAST) begin
                j_d = {CW{1'b0}};
                i_d = i_q + CW'(1);
            end else begin
                j_d = j_q + CW'(1);
            end
        end else if (inc_k_i) begin
            k_d = k_q + CW'(1);
        end else begin
            k_d = k_q;
        end
    end

    // Index registers with asynchronous reset to element (0,0), k=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= {CW{1'b0}};
            j_q <= {CW{1'b0}};
            k_q <= {CW{1'b0}};
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Matrix-multiply sequencer: walks C = A x B one element at a time
// (CLEAR, N x MAC, WRITE per element) and drives accumulator strobes and
// memory addresses. Define MATMUL_STALL_EN to add the stall input that
// freezes the sequence and suppresses strobes.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    matmul_seq_ctrl_if.master bus
);

    localparam int            CW  = $clog2(N);
    localparam logic [AW-1:0] N_A = AW'(N);

    state_e        state_q, state_d;
    logic          stall_s;
    logic          clr_s, inc_k_s, inc_ij_s;
    logic          last_k_s, last_elem_s;
    logic [CW-1:0] i_s, j_s, k_s;
    logic          busy_s, done_s, clear_res_s, res_write_s, c_write_s;

`ifdef MATMUL_STALL_EN
    assign stall_s = bus.stall;
`else
    assign stall_s = 1'b0;
`endif

    matmul_idx_cnt #(.N(N), .CW(CW)) u_idx (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_s),
        .inc_k_i     (inc_k_s),
        .inc_ij_i    (inc_ij_s),
        .i_o         (i_s),
        .j_o         (j_s),
        .k_o         (k_s),
        .last_k_o    (last_k_s),
        .last_elem_o (last_elem_s)
    );

    // State register; reset aborts any run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter control and strobe decode from the current state.
    always_comb begin
        state_d     = state_q;
        clr_s       = 1'b0;
        inc_k_s     = 1'b0;
        inc_ij_s    = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        clear_res_s = 1'b0;
        res_write_s = 1'b0;
        c_write_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                    clr_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                busy_s      = 1'b1;
                clear_res_s = ~stall_s;
                if (!stall_s) begin
                    state_d = MAC;
                end else begin
                    state_d = CLEAR;
                end
            end
            MAC: begin
                busy_s      = 1'b1;
                res_write_s = ~stall_s;
                if (stall_s) begin
                    state_d = MAC;
                end else if (last_k_s) begin
                    state_d = WRITE;
                end else begin
                    inc_k_s = 1'b1;
                end
            end
            WRITE: begin
                busy_s    = 1'b1;
                c_write_s = ~stall_s;
                if (!stall_s) begin
                    inc_ij_s = 1'b1;
                    state_d  = last_elem_s ? DONE : CLEAR;
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                done_s  = 1'b1;
                clr_s   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                clr_s   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_s;
    assign bus.done     = done_s;
    assign bus.clearRes = clear_res_s;
    assign bus.Reswrite = res_write_s;
    assign bus.cWrite   = c_write_s;
    // Addresses follow the index counters, so they read 0 whenever the
    // counters have been cleared (reset, DONE).
    assign bus.addrA    = AW'(i_s) * N_A + AW'(k_s);
    assign bus.addrB    = AW'(k_s) * N_A + AW'(j_s);
    assign bus.addrC    = AW'(i_s) * N_A + AW'(j_s);

endmodule
